// File: rtl/m2_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : m2_block_scheduler
// Brief    : Milestone 2 IDCT sequencer. Walks 2400 Y/U/V 8x8 blocks and
//            overlaps fetch, compute-T, compute-S and write-back in two phases.
// Revision : 1.0 - initial release
// ============================================================================

module m2_block_addr_gen #(
    parameter int Y_BASE      = 0,
    parameter int U_BASE      = 0,
    parameter int V_BASE      = 0,
    parameter int COL_SHIFT   = 3,
    parameter int Y_STRIDE    = 320,
    parameter int UV_STRIDE   = 160,
    parameter int Y_BLK_COLS  = 40,
    parameter int UV_BLK_COLS = 20,
    parameter int BLK_ROWS    = 30
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        i_advance,
    output logic [17:0] o_addr,
    output logic [8:0]  o_stride
);
    localparam logic [1:0]  c_SEG_Y       = 2'd0;
    localparam logic [1:0]  c_SEG_U       = 2'd1;
    localparam logic [1:0]  c_SEG_V       = 2'd2;
    localparam logic [17:0] c_Y_BASE      = 18'(Y_BASE);
    localparam logic [17:0] c_U_BASE      = 18'(U_BASE);
    localparam logic [17:0] c_V_BASE      = 18'(V_BASE);
    localparam logic [17:0] c_Y_ROW_STEP  = 18'(8 * Y_STRIDE);
    localparam logic [17:0] c_UV_ROW_STEP = 18'(8 * UV_STRIDE);
    localparam logic [5:0]  c_Y_LAST_COL  = 6'(Y_BLK_COLS - 1);
    localparam logic [5:0]  c_UV_LAST_COL = 6'(UV_BLK_COLS - 1);
    localparam logic [4:0]  c_LAST_ROW    = 5'(BLK_ROWS - 1);

    logic [1:0]  r_seg;
    logic [4:0]  r_row;
    logic [5:0]  r_col;
    logic [17:0] r_row_base;

    logic        w_is_y;
    logic [17:0] w_seg_base;
    logic [5:0]  w_last_col;
    logic [17:0] w_row_step;

    always_comb begin
        w_is_y     = (r_seg == c_SEG_Y);
        w_last_col = w_is_y ? c_Y_LAST_COL : c_UV_LAST_COL;
        w_row_step = w_is_y ? c_Y_ROW_STEP : c_UV_ROW_STEP;
        o_stride   = w_is_y ? 9'(Y_STRIDE) : 9'(UV_STRIDE);
        case (r_seg)
            c_SEG_U: w_seg_base = c_U_BASE;
            c_SEG_V: w_seg_base = c_V_BASE;
            default: w_seg_base = c_Y_BASE;
        endcase
        o_addr = w_seg_base + r_row_base + ({12'd0, r_col} << COL_SHIFT);
    end

    // Raster order within a segment; V wraps back to Y so a new frame starts clean.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_seg      <= c_SEG_Y;
            r_row      <= 5'd0;
            r_col      <= 6'd0;
            r_row_base <= 18'd0;
        end else if (i_advance) begin
            if (r_col != w_last_col) begin
                r_col <= r_col + 6'd1;
            end else begin
                r_col <= 6'd0;
                if (r_row != c_LAST_ROW) begin
                    r_row      <= r_row + 5'd1;
                    r_row_base <= r_row_base + w_row_step;
                end else begin
                    r_row      <= 5'd0;
                    r_row_base <= 18'd0;
                    r_seg      <= (r_seg == c_SEG_V) ? c_SEG_Y : r_seg + 2'd1;
                end
            end
        end
    end
endmodule

module m2_block_scheduler #(
    parameter int PRE_Y_BASE  = 76800,
    parameter int PRE_U_BASE  = 153600,
    parameter int PRE_V_BASE  = 192000,
    parameter int POST_Y_BASE = 0,
    parameter int POST_U_BASE = 38400,
    parameter int POST_V_BASE = 57600,
    parameter int Y_BLK_COLS  = 40,
    parameter int UV_BLK_COLS = 20,
    parameter int BLK_ROWS    = 30
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic        Busy,
    output logic        Done,
    output logic        fetch_start,
    output logic [17:0] fetch_addr,
    output logic [8:0]  fetch_stride,
    input  logic        fetch_done,
    output logic        ct_start,
    input  logic        ct_done,
    output logic        cs_start,
    input  logic        cs_done,
    output logic        write_start,
    output logic [17:0] write_addr,
    output logic [8:0]  write_stride,
    input  logic        write_done,
    output logic [11:0] block_count
);
    localparam int         c_TOTAL    = (Y_BLK_COLS + 2 * UV_BLK_COLS) * BLK_ROWS;
    localparam logic [11:0] c_LAST_BLK = 12'(c_TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LI_FETCH = 3'd1,
        S_PH_A     = 3'd2,
        S_PH_B     = 3'd3,
        S_LO_WRITE = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        w_go_fetch;
    logic        w_go_ct;
    logic        w_go_cs;
    logic        w_go_write;
    logic        w_blk_inc;
    logic        w_done_set;
    logic        w_phase_done;

    logic        r_fetch_start;
    logic        r_ct_start;
    logic        r_cs_start;
    logic        r_write_start;
    logic        r_done;
    logic [17:0] r_fetch_addr;
    logic [8:0]  r_fetch_stride;
    logic [17:0] r_write_addr;
    logic [8:0]  r_write_stride;
    logic [11:0] r_blk;

    logic        r_need_fetch;
    logic        r_need_ct;
    logic        r_need_cs;
    logic        r_need_write;
    logic        r_flag_fetch;
    logic        r_flag_ct;
    logic        r_flag_cs;
    logic        r_flag_write;

    logic [17:0] w_f_addr;
    logic [8:0]  w_f_stride;
    logic [17:0] w_w_addr;
    logic [8:0]  w_w_stride;

    m2_block_addr_gen #(
        .Y_BASE      (PRE_Y_BASE),
        .U_BASE      (PRE_U_BASE),
        .V_BASE      (PRE_V_BASE),
        .COL_SHIFT   (3),
        .Y_STRIDE    (Y_BLK_COLS * 8),
        .UV_STRIDE   (UV_BLK_COLS * 8),
        .Y_BLK_COLS  (Y_BLK_COLS),
        .UV_BLK_COLS (UV_BLK_COLS),
        .BLK_ROWS    (BLK_ROWS)
    ) u_fetch_gen (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .i_advance (r_fetch_start),
        .o_addr    (w_f_addr),
        .o_stride  (w_f_stride)
    );

    m2_block_addr_gen #(
        .Y_BASE      (POST_Y_BASE),
        .U_BASE      (POST_U_BASE),
        .V_BASE      (POST_V_BASE),
        .COL_SHIFT   (2),
        .Y_STRIDE    (Y_BLK_COLS * 4),
        .UV_STRIDE   (UV_BLK_COLS * 4),
        .Y_BLK_COLS  (Y_BLK_COLS),
        .UV_BLK_COLS (UV_BLK_COLS),
        .BLK_ROWS    (BLK_ROWS)
    ) u_write_gen (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .i_advance (r_write_start),
        .o_addr    (w_w_addr),
        .o_stride  (w_w_stride)
    );

    assign w_phase_done = (!r_need_fetch || r_flag_fetch) && (!r_need_ct || r_flag_ct) &&
                          (!r_need_cs || r_flag_cs) && (!r_need_write || r_flag_write);

    // Fetch only pairs with compute-T and write only with compute-S, keeping one SRAM user per phase.
    always_comb begin
        w_next     = r_state;
        w_go_fetch = 1'b0;
        w_go_ct    = 1'b0;
        w_go_cs    = 1'b0;
        w_go_write = 1'b0;
        w_blk_inc  = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Enable) begin
                    w_next     = S_LI_FETCH;
                    w_go_fetch = 1'b1;
                end
            end
            S_LI_FETCH: begin
                if (w_phase_done) begin
                    w_next     = S_PH_A;
                    w_go_ct    = 1'b1;
                    w_go_fetch = (r_blk != c_LAST_BLK);
                end
            end
            S_PH_A: begin
                if (w_phase_done) begin
                    w_next     = S_PH_B;
                    w_go_cs    = 1'b1;
                    w_go_write = (r_blk != 12'd0);
                end
            end
            S_PH_B: begin
                if (w_phase_done) begin
                    if (r_blk != c_LAST_BLK) begin
                        w_next     = S_PH_A;
                        w_blk_inc  = 1'b1;
                        w_go_ct    = 1'b1;
                        w_go_fetch = ((r_blk + 12'd1) != c_LAST_BLK);
                    end else begin
                        w_next     = S_LO_WRITE;
                        w_go_write = 1'b1;
                    end
                end
            end
            S_LO_WRITE: begin
                if (w_phase_done) begin
                    w_next     = S_FINISH;
                    w_done_set = 1'b1;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_fetch_start  <= 1'b0;
            r_ct_start     <= 1'b0;
            r_cs_start     <= 1'b0;
            r_write_start  <= 1'b0;
            r_done         <= 1'b0;
            r_fetch_addr   <= 18'd0;
            r_fetch_stride <= 9'd0;
            r_write_addr   <= 18'd0;
            r_write_stride <= 9'd0;
            r_blk          <= 12'd0;
            r_need_fetch   <= 1'b0;
            r_need_ct      <= 1'b0;
            r_need_cs      <= 1'b0;
            r_need_write   <= 1'b0;
            r_flag_fetch   <= 1'b0;
            r_flag_ct      <= 1'b0;
            r_flag_cs      <= 1'b0;
            r_flag_write   <= 1'b0;
        end else begin
            r_fetch_start <= w_go_fetch;
            r_ct_start    <= w_go_ct;
            r_cs_start    <= w_go_cs;
            r_write_start <= w_go_write;
            r_done        <= w_done_set;
            if (w_go_fetch) begin
                r_fetch_addr   <= w_f_addr;
                r_fetch_stride <= w_f_stride;
            end
            if (w_go_write) begin
                r_write_addr   <= w_w_addr;
                r_write_stride <= w_w_stride;
            end
            if (r_state == S_IDLE && Enable) begin
                r_blk <= 12'd0;
            end else if (w_blk_inc) begin
                r_blk <= r_blk + 12'd1;
            end
            // Done pulses in the start cycle belong to a previous job and are dropped.
            if (w_next != r_state) begin
                r_need_fetch <= w_go_fetch;
                r_need_ct    <= w_go_ct;
                r_need_cs    <= w_go_cs;
                r_need_write <= w_go_write;
                r_flag_fetch <= 1'b0;
                r_flag_ct    <= 1'b0;
                r_flag_cs    <= 1'b0;
                r_flag_write <= 1'b0;
            end else begin
                if (!r_fetch_start && fetch_done) r_flag_fetch <= 1'b1;
                if (!r_ct_start && ct_done)       r_flag_ct    <= 1'b1;
                if (!r_cs_start && cs_done)       r_flag_cs    <= 1'b1;
                if (!r_write_start && write_done) r_flag_write <= 1'b1;
            end
        end
    end

    assign Busy         = (r_state != S_IDLE);
    assign Done         = r_done;
    assign fetch_start  = r_fetch_start;
    assign fetch_addr   = r_fetch_addr;
    assign fetch_stride = r_fetch_stride;
    assign ct_start     = r_ct_start;
    assign cs_start     = r_cs_start;
    assign write_start  = r_write_start;
    assign write_addr   = r_write_addr;
    assign write_stride = r_write_stride;
    assign block_count  = r_blk;
endmodule

`default_nettype wire

// File: tb/tb_m2_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_m2_block_scheduler
// Brief    : Directed self-checking bench for m2_block_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m2_block_scheduler;
    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Enable = 1'b0;
    logic        fetch_done = 1'b0;
    logic        ct_done = 1'b0;
    logic        cs_done = 1'b0;
    logic        write_done = 1'b0;
    logic        Busy, Done, fetch_start, ct_start, cs_start, write_start;
    logic [17:0] fetch_addr, write_addr;
    logic [8:0]  fetch_stride, write_stride;
    logic [11:0] block_count;

    int checks = 0;
    int errors = 0;
    int d_f = 3, d_ct = 3, d_cs = 3, d_w = 3;

    int cyc = 0, fcnt = 0, ctcnt = 0, cscnt = 0, wcnt = 0, dcnt = 0;
    int overlap_err = 0, stab_err = 0, gap_err = 0, last_done_cyc = 0;
    int last_ct_cyc = 0, last_cs_cyc = 0, pa_len = 0, pb_len = 0;
    logic [17:0] f_log [0:4095];
    logic [8:0]  fs_log [0:4095];
    logic [17:0] w_log [0:4095];
    logic [8:0]  ws_log [0:4095];
    logic [11:0] bc_log [0:4095];
    logic [11:0] wbc_log [0:4095];
    logic [17:0] cur_f = 18'd0, cur_w = 18'd0;

    m2_block_scheduler dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Enable       (Enable),
        .Busy         (Busy),
        .Done         (Done),
        .fetch_start  (fetch_start),
        .fetch_addr   (fetch_addr),
        .fetch_stride (fetch_stride),
        .fetch_done   (fetch_done),
        .ct_start     (ct_start),
        .ct_done      (ct_done),
        .cs_start     (cs_start),
        .cs_done      (cs_done),
        .write_start  (write_start),
        .write_addr   (write_addr),
        .write_stride (write_stride),
        .write_done   (write_done),
        .block_count  (block_count)
    );

    always #5 Clock = ~Clock;

    // Unit models: each answers a start with a one-cycle done d cycles later.
    initial forever begin
        @(negedge Clock);
        if (fetch_start) begin
            repeat (d_f) @(posedge Clock);
            #1 fetch_done = 1'b1;
            @(posedge Clock);
            #1 fetch_done = 1'b0;
        end
    end
    initial forever begin
        @(negedge Clock);
        if (ct_start) begin
            repeat (d_ct) @(posedge Clock);
            #1 ct_done = 1'b1;
            @(posedge Clock);
            #1 ct_done = 1'b0;
        end
    end
    initial forever begin
        @(negedge Clock);
        if (cs_start) begin
            repeat (d_cs) @(posedge Clock);
            #1 cs_done = 1'b1;
            @(posedge Clock);
            #1 cs_done = 1'b0;
        end
    end
    initial forever begin
        @(negedge Clock);
        if (write_start) begin
            repeat (d_w) @(posedge Clock);
            #1 write_done = 1'b1;
            @(posedge Clock);
            #1 write_done = 1'b0;
        end
    end

    // Observer: logs every start and tracks phase spacing and SRAM exclusivity.
    always @(negedge Clock) begin
        cyc++;
        if (fetch_start && (write_start || cs_start)) overlap_err++;
        if (write_start && (fetch_start || ct_start)) overlap_err++;
        if ((ct_start || cs_start || write_start || Done) && (cyc - last_done_cyc != 2)) gap_err++;
        if (fetch_start) begin
            if (fcnt < 4096) begin
                f_log[fcnt[11:0]]  = fetch_addr;
                fs_log[fcnt[11:0]] = fetch_stride;
            end
            cur_f = fetch_addr;
            fcnt++;
        end
        if (ct_start) begin
            if (ctcnt < 4096) bc_log[ctcnt[11:0]] = block_count;
            pb_len      = cyc - last_cs_cyc;
            last_ct_cyc = cyc;
            ctcnt++;
        end
        if (cs_start) begin
            pa_len      = cyc - last_ct_cyc;
            last_cs_cyc = cyc;
            cscnt++;
        end
        if (write_start) begin
            if (wcnt < 4096) begin
                w_log[wcnt[11:0]]   = write_addr;
                ws_log[wcnt[11:0]]  = write_stride;
                wbc_log[wcnt[11:0]] = block_count;
            end
            cur_w = write_addr;
            wcnt++;
        end
        if (Done) dcnt++;
        if (Resetn && fetch_done && fetch_addr !== cur_f) stab_err++;
        if (Resetn && write_done && write_addr !== cur_w) stab_err++;
        if (fetch_done || ct_done || cs_done || write_done) last_done_cyc = cyc;
    end

    task automatic start_run;
        @(negedge Clock);
        Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        checks++; if ({Busy, Done, fetch_start, ct_start, cs_start, write_start} !== 6'd0) begin errors++; $display("FAIL reset_ctrl got %b want 000000", {Busy, Done, fetch_start, ct_start, cs_start, write_start}); end
        checks++; if ({fetch_addr, write_addr} !== 36'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d want 0/0", fetch_addr, write_addr); end
        checks++; if ({fetch_stride, write_stride, block_count} !== 30'd0) begin errors++; $display("FAIL reset_stride_count got %0d/%0d/%0d want 0/0/0", fetch_stride, write_stride, block_count); end
        @(posedge Clock);
        #1 Resetn = 1'b1;
    endtask

    task automatic test_full_run;
        bit ok;
        start_run();
        for (int i = 0; i < 30000; i++) begin
            if (Done) break;
            @(negedge Clock);
            Enable = (i == 1000);
        end
        ok = Done;
        if (ok) begin
            Enable = 1'b1;
            @(negedge Clock);
        end
        Enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL full_run_timeout got no Done want Done within 30000 cycles"); end
    endtask

    task automatic test_first_blocks;
        checks++; if (f_log[0] !== 18'd76800) begin errors++; $display("FAIL first_fetch_addr got %0d want 76800", f_log[0]); end
        checks++; if (fs_log[0] !== 9'd320) begin errors++; $display("FAIL first_fetch_stride got %0d want 320", fs_log[0]); end
        checks++; if (f_log[1] !== 18'd76808) begin errors++; $display("FAIL second_fetch_addr got %0d want 76808", f_log[1]); end
        checks++; if (bc_log[0] !== 12'd0) begin errors++; $display("FAIL first_ct_block got %0d want 0", bc_log[0]); end
        checks++; if (w_log[0] !== 18'd0 || ws_log[0] !== 9'd160) begin errors++; $display("FAIL first_write got %0d/%0d want 0/160", w_log[0], ws_log[0]); end
        checks++; if (wbc_log[0] !== 12'd1) begin errors++; $display("FAIL first_write_phase got block %0d want 1", wbc_log[0]); end
    endtask

    task automatic test_y_wrap;
        checks++; if (f_log[39] !== 18'd77112 || w_log[39] !== 18'd156) begin errors++; $display("FAIL y_row_end got %0d/%0d want 77112/156", f_log[39], w_log[39]); end
        checks++; if (f_log[40] !== 18'd79360) begin errors++; $display("FAIL y_wrap_fetch got %0d want 79360", f_log[40]); end
        checks++; if (w_log[40] !== 18'd1280) begin errors++; $display("FAIL y_wrap_write got %0d want 1280", w_log[40]); end
    endtask

    task automatic test_segments;
        checks++; if (f_log[1200] !== 18'd153600 || fs_log[1200] !== 9'd160) begin errors++; $display("FAIL u_fetch got %0d/%0d want 153600/160", f_log[1200], fs_log[1200]); end
        checks++; if (w_log[1200] !== 18'd38400 || ws_log[1200] !== 9'd80) begin errors++; $display("FAIL u_write got %0d/%0d want 38400/80", w_log[1200], ws_log[1200]); end
        checks++; if (f_log[1220] !== 18'd154880 || w_log[1220] !== 18'd39040) begin errors++; $display("FAIL u_wrap got %0d/%0d want 154880/39040", f_log[1220], w_log[1220]); end
        checks++; if (f_log[1800] !== 18'd192000 || w_log[1800] !== 18'd57600) begin errors++; $display("FAIL v_start got %0d/%0d want 192000/57600", f_log[1800], w_log[1800]); end
        checks++; if (bc_log[1200] !== 12'd1200) begin errors++; $display("FAIL block_count_1200 got %0d want 1200", bc_log[1200]); end
    endtask

    task automatic test_completion;
        repeat (5) @(negedge Clock);
        checks++; if (f_log[2399] !== 18'd229272 || w_log[2399] !== 18'd76236) begin errors++; $display("FAIL last_addrs got %0d/%0d want 229272/76236", f_log[2399], w_log[2399]); end
        checks++; if (fcnt != 2400 || ctcnt != 2400 || cscnt != 2400 || wcnt != 2400) begin errors++; $display("FAIL start_counts got %0d/%0d/%0d/%0d want 2400 each", fcnt, ctcnt, cscnt, wcnt); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL done_count got %0d want 1", dcnt); end
        checks++; if (Busy !== 1'b0 || block_count !== 12'd2399) begin errors++; $display("FAIL idle_after got busy=%b count=%0d want 0/2399", Busy, block_count); end
        checks++; if (gap_err != 0 || overlap_err != 0 || stab_err != 0) begin errors++; $display("FAIL run_rules got gap=%0d overlap=%0d stable=%0d want 0/0/0", gap_err, overlap_err, stab_err); end
        checks++; if (pa_len != 5 || pb_len != 5) begin errors++; $display("FAIL phase_len_3 got %0d/%0d want 5/5", pa_len, pb_len); end
    endtask

    task automatic test_phase_timing;
        int c0;
        c0 = ctcnt;
        d_f = 2; d_ct = 12; d_cs = 4; d_w = 4;
        start_run();
        for (int i = 0; i < 500; i++) begin
            if (ctcnt >= c0 + 10) break;
            @(negedge Clock);
        end
        checks++; if (ctcnt < c0 + 10) begin errors++; $display("FAIL phase_timeout got %0d ct starts want 10", ctcnt - c0); end
        checks++; if (pa_len != 14 || pb_len != 6) begin errors++; $display("FAIL phase_len got %0d/%0d want 14/6", pa_len, pb_len); end
        checks++; if (gap_err != 0 || overlap_err != 0) begin errors++; $display("FAIL phase_rules got gap=%0d overlap=%0d want 0/0", gap_err, overlap_err); end
    endtask

    task automatic test_reset_mid;
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 15000; i++) begin
            if (cs_start && block_count == 12'd500) begin hit = 1'b1; break; end
            @(negedge Clock);
        end
        checks++; if (!hit) begin errors++; $display("FAIL reach_block_500 got no PH_B(500) want it within 15000 cycles"); end
        @(negedge Clock);
        Resetn = 1'b0;
        #1;
        checks++; if ({Busy, Done, fetch_start, ct_start, cs_start, write_start} !== 6'd0 || {fetch_addr, write_addr, fetch_stride, write_stride, block_count} !== 66'd0) begin errors++; $display("FAIL mid_reset_outputs got busy=%b f=%0d w=%0d cnt=%0d want all 0", Busy, fetch_addr, write_addr, block_count); end
        repeat (20) @(negedge Clock);
        Resetn = 1'b1;
        start_run();
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fetch_start) begin hit = 1'b1; break; end
            @(negedge Clock);
        end
        checks++; if (!hit || fetch_addr !== 18'd76800 || fetch_stride !== 9'd320) begin errors++; $display("FAIL restart_fetch got seen=%b %0d/%0d want 76800/320", hit, fetch_addr, fetch_stride); end
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ct_start) begin hit = 1'b1; break; end
            @(negedge Clock);
        end
        checks++; if (!hit || block_count !== 12'd0 || fetch_addr !== 18'd76808) begin errors++; $display("FAIL restart_ph_a got seen=%b cnt=%0d f=%0d want 0/76808", hit, block_count, fetch_addr); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_first_blocks();
        test_y_wrap();
        test_segments();
        test_completion();
        test_phase_timing();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
